dphy_hs_tx_sequencer: RTL and testbench
=======================================

// Module: dphy_hs_tx_sequencer
// PURPOSE
//  Controller for the 4-lane D-PHY transmit datapath. Takes a byte stream from the DSI packet layer
//  and sequences each burst: LP-11 stop, LP-01, LP-00, HS-zero, sync byte, payload, HS-trail, then
//  back to LP-11. Drives the lane-level nibble bus plus the low-power line state.
//  Sits between the packet builder (upstream) and the lane I/O register stage (downstream).
// PARAMETERS
//  T_LPX     4      cycles in LP-01 (request state)
//  T_PREP    3      cycles in LP-00 (HS-prepare)
//  T_ZERO    8      cycles of HS-zero (hs_data=4'h0, hs_en=1)
//  T_TRAIL   6      cycles of HS-trail
//  T_EXIT    4      cycles of LP-11 after trail before a new tx_req is honoured
//  SYNC_BYTE 8'hB8  leader byte sent after HS-zero, low nibble first
// PORTS
//  clk        in   1  sole clock; all state updates on posedge clk
//  rst_n      in   1  asynchronous, active-low reset
//  tx_req     in   1  level request for an HS burst; sampled only in IDLE
//  tx_busy    out  1  high in every state except IDLE
//  in_data    in   8  payload byte
//  in_valid   in   1  in_data/in_last valid
//  in_last    in   1  marks final byte of burst
//  in_ready   out  1  byte accepted on cycle where in_valid && in_ready
//  hs_data    out  4  lane nibble, bit i -> lane Di; 1 nibble per cycle, byte low nibble first
//  hs_en      out  1  HS drivers enabled (HS_ZERO, SYNC, DATA, TRAIL)
//  lp_state   out  2  {Dp,Dn} LP level, common to all lanes: 2'b11, 2'b01, 2'b00
//  tx_done    out  1  one-cycle pulse on last cycle of TRAIL
//  underflow  out  1  one-cycle pulse when a byte was needed and in_valid was low
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, lp_state=2'b11, hs_data=0, hs_en=0, in_ready=0,
//   tx_busy=0, tx_done=0, underflow=0, timer=0, phase=0, holding reg cleared.
//   Assertion mid-burst aborts immediately; outputs take reset values same instant.
//  States / timed dwell (each timed state lasts exactly its parameter cycles, down-counter loaded on entry):
//   IDLE    lp=11; tx_req=1 at edge k -> LP01 at k+1 (latency 1).
//   LP01    lp=01, T_LPX cycles -> LP00.
//   LP00    lp=00, T_PREP cycles -> HS_ZERO.
//   HS_ZERO hs_en=1, hs_data=0, T_ZERO cycles -> SYNC.
//   SYNC    2 cycles: SYNC_BYTE[3:0] then [7:4]; in_ready=1 on 2nd cycle -> DATA.
//   DATA    2 cycles per byte (phase 0: byte[3:0], phase 1: byte[7:4]); in_ready=1 in phase 1
//           unless the byte in flight has last=1. Byte accepted in phase 1 is sent starting next cycle.
//           At phase 1 end with last byte in flight -> TRAIL.
//   TRAIL   hs_en=1, hs_data = ~(last nibble driven), T_TRAIL cycles; tx_done on final cycle -> EXIT.
//   EXIT    lp=11, hs_en=0, T_EXIT cycles; tx_req ignored -> IDLE.
//  lp_state=2'b00 throughout HS_ZERO..TRAIL (don't-care at PHY, fixed for checking).
//  Underflow: in_ready=1 but in_valid=0 (SYNC 2nd cycle or DATA phase 1 without last) ->
//   underflow pulse that cycle, no byte taken, next state TRAIL (burst truncated, trail inverts
//   last nibble driven). Empty burst (in_valid=0 after SYNC) therefore = SYNC + TRAIL + underflow.
//  in_ready is Moore (no combinational path from in_valid). Byte held in 8-bit register.
//  tx_req dropping after acceptance does not abort; burst ends only on last/underflow/reset.
//  Timer 8 bits; all T_* parameters must be 1..255 (elaboration-time check).
//  tx_busy=1 from LP01 through EXIT inclusive.
// STRUCTURE
//  Package dphy_pkg: state enum (IDLE,LP01,LP00,HS_ZERO,SYNC,DATA,TRAIL,EXIT), LP level constants
//   LP11/LP01/LP00, default SYNC_BYTE, TIMER_W=8.
//  Sub-module dphy_dwell_timer: loadable 8-bit down-counter with 'expire' flag; FSM loads it on
//   every timed-state entry. Remaining FSM, phase bit, holding register in this module.
// TESTING
//  1 Reset: rst_n=0 -> lp_state=11, hs_en=0, tx_busy=0, in_ready=0; tx_req=1 ignored while low.
//  2 One-byte burst 8'h5A last=1, defaults: LP01 4 cyc, LP00 3, zero 8, hs_data 8,B,A,5, trail
//    6 cyc of 4'hA, tx_done pulse, EXIT 4 cyc, total 1+4+3+8+2+2+6+4 cycles from tx_req.
//  3 Three-byte burst 01,23,45 with in_valid always 1: in_ready pulses every 2nd cycle, hs_data
//    1,0,3,2,5,4, no underflow, trail=4'hB.
//  4 in_valid dropped before byte 2 of 3: underflow pulse at DATA phase 1, trail = ~byte1[7:4].
//  5 rst_n asserted during HS_ZERO cycle 3: outputs LP-11/hs_en=0 immediately; new tx_req
//    after release runs full sequence from LP01.
//  6 tx_req held high through EXIT: IDLE entered for 1 cycle then LP01 (no back-to-back bypass).

Source files
------------

// File: rtl/dphy_pkg.sv
// Shared types and constants for the D-PHY HS transmit sequencer.
// Holds the burst state encoding, the LP line levels and the timer width.
package dphy_pkg;

    localparam int TIMER_W = 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LP01    = 3'd1,
        S_LP00    = 3'd2,
        S_HS_ZERO = 3'd3,
        S_SYNC    = 3'd4,
        S_DATA    = 3'd5,
        S_TRAIL   = 3'd6,
        S_EXIT    = 3'd7
    } state_t;

    localparam logic [1:0] LP11 = 2'b11;
    localparam logic [1:0] LP01 = 2'b01;
    localparam logic [1:0] LP00 = 2'b00;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hB8;

    // A dwell value must fit the down-counter and be at least one cycle.
    function automatic logic dwell_ok(input int unsigned v);
        return (v >= 32'd1) && (v <= 32'd255);
    endfunction

endpackage

// File: rtl/dphy_dwell_timer.sv
// Loadable down-counter used to time each fixed-length burst state.
// The loaded value is visible on the first cycle of the state; expire marks its last cycle.
module dphy_dwell_timer
    import dphy_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    output logic [TIMER_W-1:0] count,
    output logic               expire
);

    logic [TIMER_W-1:0] count_r;

    // Counter: reload on state entry, otherwise count down and stop at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {TIMER_W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (count_r != {TIMER_W{1'b0}}) begin
            count_r <= count_r - TIMER_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count  = count_r;
    assign expire = (count_r == TIMER_W'(1));

endmodule

// File: rtl/dphy_hs_tx_sequencer.sv
// Sequences one D-PHY HS burst per request: LP-11, LP-01, LP-00, HS-zero, sync, payload, trail, exit.
// Outputs are registered from next-state values so they line up with the state they describe.
module dphy_hs_tx_sequencer
    import dphy_pkg::*;
#(
    parameter int unsigned T_LPX     = 4,
    parameter int unsigned T_PREP    = 3,
    parameter int unsigned T_ZERO    = 8,
    parameter int unsigned T_TRAIL   = 6,
    parameter int unsigned T_EXIT    = 4,
    parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_req,
    output logic       tx_busy,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [3:0] hs_data,
    output logic       hs_en,
    output logic [1:0] lp_state,
    output logic       tx_done,
    output logic       underflow
);

    if (!dwell_ok(T_LPX) || !dwell_ok(T_PREP) || !dwell_ok(T_ZERO) ||
        !dwell_ok(T_TRAIL) || !dwell_ok(T_EXIT)) begin : g_bad_dwell
        $error("dphy_hs_tx_sequencer: every T_* dwell must be in 1..255");
    end

    state_t             state_r, nxt_state_s;
    logic               phase_r, nxt_phase_s;
    logic [7:0]         hold_r, nxt_hold_s;
    logic               last_r, nxt_last_s;
    logic               tmr_load_s;
    logic [TIMER_W-1:0] tmr_val_s;
    logic [TIMER_W-1:0] tmr_count_s;
    logic               tmr_expire_s;
    logic               accept_s;
    logic               starve_s;

    logic [1:0]         lp_state_r, lp_state_s;
    logic               hs_en_r, hs_en_s;
    logic [3:0]         hs_data_r, hs_data_s;
    logic               tx_busy_r, tx_busy_s;
    logic               in_ready_r, in_ready_s;
    logic               tx_done_r, tx_done_s;

    dphy_dwell_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .count    (tmr_count_s),
        .expire   (tmr_expire_s)
    );

    assign accept_s = in_ready_r & in_valid;
    assign starve_s = in_ready_r & ~in_valid;

    // Next-state logic: state, nibble phase, held byte and timer loads.
    always_comb begin
        nxt_state_s = state_r;
        nxt_phase_s = phase_r;
        nxt_hold_s  = hold_r;
        nxt_last_s  = last_r;
        tmr_load_s  = 1'b0;
        tmr_val_s   = {TIMER_W{1'b0}};
        case (state_r)
            S_IDLE: begin
                if (tx_req) begin
                    nxt_state_s = S_LP01;
                    tmr_load_s  = 1'b1;
                    tmr_val_s   = TIMER_W'(T_LPX);
                end else begin
                    nxt_state_s = S_IDLE;
                end
            end
            S_LP01: begin
                if (tmr_expire_s) begin
                    nxt_state_s = S_LP00;
                    tmr_load_s  = 1'b1;
                    tmr_val_s   = TIMER_W'(T_PREP);
                end else begin
                    nxt_state_s = S_LP01;
                end
            end
            S_LP00: begin
                if (tmr_expire_s) begin
                    nxt_state_s = S_HS_ZERO;
                    tmr_load_s  = 1'b1;
                    tmr_val_s   = TIMER_W'(T_ZERO);
                end else begin
                    nxt_state_s = S_LP00;
                end
            end
            S_HS_ZERO: begin
                if (tmr_expire_s) begin
                    nxt_state_s = S_SYNC;
                    nxt_phase_s = 1'b0;
                end else begin
                    nxt_state_s = S_HS_ZERO;
                end
            end
            S_SYNC, S_DATA: begin
                // Phase 1 is where the next byte is fetched, or the burst ends.
                if (!phase_r) begin
                    nxt_phase_s = 1'b1;
                end else if ((state_r == S_DATA) && last_r) begin
                    nxt_state_s = S_TRAIL;
                    tmr_load_s  = 1'b1;
                    tmr_val_s   = TIMER_W'(T_TRAIL);
                end else if (accept_s) begin
                    nxt_state_s = S_DATA;
                    nxt_phase_s = 1'b0;
                    nxt_hold_s  = in_data;
                    nxt_last_s  = in_last;
                end else begin
                    nxt_state_s = S_TRAIL;
                    tmr_load_s  = 1'b1;
                    tmr_val_s   = TIMER_W'(T_TRAIL);
                end
            end
            S_TRAIL: begin
                if (tmr_expire_s) begin
                    nxt_state_s = S_EXIT;
                    tmr_load_s  = 1'b1;
                    tmr_val_s   = TIMER_W'(T_EXIT);
                end else begin
                    nxt_state_s = S_TRAIL;
                end
            end
            S_EXIT: begin
                if (tmr_expire_s) begin
                    nxt_state_s = S_IDLE;
                end else begin
                    nxt_state_s = S_EXIT;
                end
            end
            default: begin
                nxt_state_s = S_IDLE;
            end
        endcase
    end

    // Output decode from the values the state registers are about to take.
    always_comb begin
        lp_state_s = LP00;
        hs_en_s    = 1'b0;
        hs_data_s  = 4'h0;
        tx_busy_s  = 1'b1;
        in_ready_s = 1'b0;
        tx_done_s  = 1'b0;
        case (nxt_state_s)
            S_IDLE: begin
                lp_state_s = LP11;
                tx_busy_s  = 1'b0;
            end
            S_LP01: begin
                lp_state_s = LP01;
            end
            S_LP00: begin
                lp_state_s = LP00;
            end
            S_HS_ZERO: begin
                hs_en_s = 1'b1;
            end
            S_SYNC: begin
                hs_en_s    = 1'b1;
                hs_data_s  = nxt_phase_s ? SYNC_BYTE[7:4] : SYNC_BYTE[3:0];
                in_ready_s = nxt_phase_s;
            end
            S_DATA: begin
                hs_en_s    = 1'b1;
                hs_data_s  = nxt_phase_s ? nxt_hold_s[7:4] : nxt_hold_s[3:0];
                in_ready_s = nxt_phase_s & ~nxt_last_s;
            end
            S_TRAIL: begin
                // Trail drives the complement of the final HS nibble, held for the whole dwell.
                hs_en_s = 1'b1;
                if (state_r == S_TRAIL) begin
                    hs_data_s = hs_data_r;
                    tx_done_s = (tmr_count_s == TIMER_W'(2));
                end else begin
                    hs_data_s = ~hs_data_r;
                    tx_done_s = (T_TRAIL == 32'd1);
                end
            end
            S_EXIT: begin
                lp_state_s = LP11;
            end
            default: begin
                lp_state_s = LP11;
                tx_busy_s  = 1'b0;
            end
        endcase
    end

    // State, holding register and registered lane outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            phase_r    <= 1'b0;
            hold_r     <= 8'h00;
            last_r     <= 1'b0;
            lp_state_r <= LP11;
            hs_en_r    <= 1'b0;
            hs_data_r  <= 4'h0;
            tx_busy_r  <= 1'b0;
            in_ready_r <= 1'b0;
            tx_done_r  <= 1'b0;
        end else begin
            state_r    <= nxt_state_s;
            phase_r    <= nxt_phase_s;
            hold_r     <= nxt_hold_s;
            last_r     <= nxt_last_s;
            lp_state_r <= lp_state_s;
            hs_en_r    <= hs_en_s;
            hs_data_r  <= hs_data_s;
            tx_busy_r  <= tx_busy_s;
            in_ready_r <= in_ready_s;
            tx_done_r  <= tx_done_s;
        end
    end

    assign lp_state  = lp_state_r;
    assign hs_en     = hs_en_r;
    assign hs_data   = hs_data_r;
    assign tx_busy   = tx_busy_r;
    assign in_ready  = in_ready_r;
    assign tx_done   = tx_done_r;
    // Starvation is flagged in the very cycle the missing byte was wanted.
    assign underflow = starve_s;

endmodule

// File: tb/tb_dphy_hs_tx_sequencer.sv
// Self-checking bench: a burst-level model expands each burst into its expected per-cycle outputs.
module tb_dphy_hs_tx_sequencer;
    import dphy_pkg::*;

    localparam int T_LPX   = 4;
    localparam int T_PREP  = 3;
    localparam int T_ZERO  = 8;
    localparam int T_TRAIL = 6;
    localparam int T_EXIT  = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tx_req;
    logic       tx_busy;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic [3:0] hs_data;
    logic       hs_en;
    logic [1:0] lp_state;
    logic       tx_done;
    logic       underflow;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  bytes [0:7];
    logic [10:0] exp_q [$];
    logic [10:0] idle_v;

    dphy_hs_tx_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tx_req    (tx_req),
        .tx_busy   (tx_busy),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .hs_data   (hs_data),
        .hs_en     (hs_en),
        .lp_state  (lp_state),
        .tx_done   (tx_done),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] pk(input logic [1:0] lp, input logic en, input logic [3:0] d,
                                       input logic busy, input logic rdy, input logic done,
                                       input logic uf);
        return {lp, en, d, busy, rdy, done, uf};
    endfunction

    function automatic logic [10:0] observed();
        return {lp_state, hs_en, hs_data, tx_busy, in_ready, tx_done, underflow};
    endfunction

    task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed={lp,en,data,busy,rdy,done,uf}=%b expected=%b", tag, obs, expv);
        end
    endtask

    // Expand a burst of n bytes, of which only the first d are ever offered, into per-cycle outputs.
    task automatic build_model(input int n, input int d);
        logic [7:0] sb;
        logic [3:0] lastn;
        sb = SYNC_BYTE_DEF;
        exp_q.delete();
        repeat (T_LPX)  exp_q.push_back(pk(2'b01, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0));
        repeat (T_PREP) exp_q.push_back(pk(2'b00, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0));
        repeat (T_ZERO) exp_q.push_back(pk(2'b00, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(pk(2'b00, 1'b1, sb[3:0], 1'b1, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(pk(2'b00, 1'b1, sb[7:4], 1'b1, 1'b1, 1'b0, d == 0));
        lastn = sb[7:4];
        for (int i = 0; i < d; i++) begin
            exp_q.push_back(pk(2'b00, 1'b1, bytes[i][3:0], 1'b1, 1'b0, 1'b0, 1'b0));
            exp_q.push_back(pk(2'b00, 1'b1, bytes[i][7:4], 1'b1, i != n - 1, 1'b0,
                               (i == d - 1) && (d < n)));
            lastn = bytes[i][7:4];
        end
        for (int t = 0; t < T_TRAIL; t++)
            exp_q.push_back(pk(2'b00, 1'b1, ~lastn, 1'b1, 1'b0, t == T_TRAIL - 1, 1'b0));
        repeat (T_EXIT) exp_q.push_back(pk(2'b11, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0));
    endtask

    // Run one burst from IDLE; abort_at >= 0 asserts reset during that cycle index.
    task automatic run_burst(input string name, input int n, input int d, input bit hold,
                             input int abort_at);
        int idx;
        build_model(n, d);
        idx = 0;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        #1;
        chk({name, " idle"}, observed(), idle_v);
        tx_req = 1'b1;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            if (!hold) tx_req = 1'b0;
            in_valid = (idx < d);
            in_data  = (idx < d) ? bytes[idx] : 8'h00;
            in_last  = (idx == n - 1);
            #1;
            chk($sformatf("%s k=%0d", name, k), observed(), exp_q[k]);
            if (k == abort_at) begin
                #2 rst_n = 1'b0;
                #1 chk({name, " abort"}, observed(), idle_v);
                in_valid = 1'b0;
                return;
            end
            if (in_ready && in_valid) idx++;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        idle_v   = pk(2'b11, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n    = 1'b0;
        tx_req   = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;

        // Reset holds the sequencer idle even with a pending request.
        repeat (3) begin
            @(negedge clk);
            #1 chk("reset", observed(), idle_v);
        end
        tx_req = 1'b0;
        rst_n  = 1'b1;

        bytes[0] = 8'h5A;
        run_burst("one_byte", 1, 1, 1'b0, -1);

        bytes[0] = 8'h01; bytes[1] = 8'h23; bytes[2] = 8'h45;
        run_burst("three_byte", 3, 3, 1'b0, -1);

        run_burst("underflow", 3, 1, 1'b0, -1);

        run_burst("empty", 2, 0, 1'b0, -1);

        // Reset during the third HS-zero cycle, then a full burst after release.
        run_burst("abort", 2, 2, 1'b0, T_LPX + T_PREP + 2);
        tx_req = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1 chk("abort_hold", observed(), idle_v);
        end
        tx_req = 1'b0;
        rst_n  = 1'b1;
        run_burst("after_abort", 2, 2, 1'b0, -1);

        // Request held through EXIT: exactly one IDLE cycle before the next burst.
        bytes[0] = 8'hC3;
        run_burst("held_req", 1, 1, 1'b1, -1);
        bytes[0] = 8'h7E; bytes[1] = 8'h81;
        run_burst("held_next", 2, 2, 1'b0, -1);

        for (int r = 0; r < 5; r++) begin
            int n;
            int d;
            n = $urandom_range(1, 5);
            d = (($urandom_range(0, 2)) == 0) ? $urandom_range(0, n - 1) : n;
            for (int b = 0; b < 8; b++) bytes[b] = 8'($urandom);
            run_burst($sformatf("rand%0d", r), n, d, 1'b0, -1);
        end

        @(negedge clk);
        #1 chk("final_idle", observed(), idle_v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
